// File: rtl/rf_hazard_ctl.sv
// Register-fetch hazard scheduler: tracks in-flight GPR writes (EX/MEM/WB), selects
// operand forwarding sources, and raises stall/bubble for load-use and mul/div-busy hazards.
module rf_hazard_ctl #(
    parameter int MD_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       pause,
    input  logic       flush_i,
    input  logic [4:0] rs_n_i,
    input  logic [4:0] rt_n_i,
    input  logic       use_rs_i,
    input  logic       use_rt_i,
    input  logic       wr_en_i,
    input  logic [4:0] wr_addr_i,
    input  logic       is_load_i,
    input  logic       md_start_i,
    input  logic       md_read_i,
    output logic [2:0] fw_cmp_rs,
    output logic [2:0] fw_cmp_rt,
    output logic       stall_o,
    output logic       bubble_o,
    output logic       md_busy_o
);

    localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES);

    // Slot p0 = EX, p1 = MEM, p2 = WB
    logic       vld_p0, vld_p1, vld_p2;
    logic [4:0] addr_p0, addr_p1, addr_p2;
    logic       load_p0;
    logic [5:0] md_cnt;

    logic rs_ex, rt_ex;
    logic ld_stall, md_stall, stall, issue;

    function automatic logic hit(input logic use_op, input logic [4:0] op,
                                 input logic vld, input logic [4:0] addr);
        return use_op && vld && (addr == op) && (op != 5'd0);
    endfunction

    // Youngest matching slot wins; $0 never matches
    function automatic logic [2:0] fw_sel(input logic use_op, input logic [4:0] op,
                                          input logic v0, input logic [4:0] a0,
                                          input logic v1, input logic [4:0] a1,
                                          input logic v2, input logic [4:0] a2);
        if (hit(use_op, op, v0, a0))      return 3'b001;
        else if (hit(use_op, op, v1, a1)) return 3'b010;
        else if (hit(use_op, op, v2, a2)) return 3'b011;
        else                              return 3'b000;
    endfunction

    always_comb begin
        fw_cmp_rs = fw_sel(use_rs_i, rs_n_i, vld_p0, addr_p0, vld_p1, addr_p1, vld_p2, addr_p2);
        fw_cmp_rt = fw_sel(use_rt_i, rt_n_i, vld_p0, addr_p0, vld_p1, addr_p1, vld_p2, addr_p2);
        rs_ex     = hit(use_rs_i, rs_n_i, vld_p0, addr_p0);
        rt_ex     = hit(use_rt_i, rt_n_i, vld_p0, addr_p0);
    end

    assign md_busy_o = (md_cnt != 6'd0);
    assign ld_stall  = (rs_ex || rt_ex) && load_p0;
    assign md_stall  = (md_read_i || md_start_i) && md_busy_o && !flush_i;
    // Pause already freezes the whole pipe, so no extra stall is requested then
    assign stall     = (ld_stall || md_stall) && !flush_i && !pause;
    assign stall_o   = stall;
    assign bubble_o  = stall;
    assign issue     = !flush_i && !stall;

    // Control: slot valids and mul/div occupancy counter
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            md_cnt <= 6'd0;
        end else if (!pause) begin
            vld_p0 <= issue && wr_en_i && (wr_addr_i != 5'd0);
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (md_start_i && issue)
                md_cnt <= MD_LOAD;
            else if (md_cnt != 6'd0)
                md_cnt <= md_cnt - 6'd1;
        end
    end

    // Data: slot contents, only meaningful while the matching valid is set
    always_ff @(posedge clk) begin
        if (!pause) begin
            addr_p0 <= wr_addr_i;
            load_p0 <= is_load_i;
            addr_p1 <= addr_p0;
            addr_p2 <= addr_p1;
        end
    end

endmodule

// File: tb/tb_rf_hazard_ctl.sv
// Bench for rf_hazard_ctl: directed hazard scenarios plus randomized traffic checked
// against an issue-history model of the scoreboard and mul/div occupancy.
module tb_rf_hazard_ctl;

    localparam int MDC = 4;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       pause;
    logic       flush_i;
    logic [4:0] rs_n_i, rt_n_i, wr_addr_i;
    logic       use_rs_i, use_rt_i, wr_en_i, is_load_i, md_start_i, md_read_i;
    logic [2:0] fw_cmp_rs, fw_cmp_rt;
    logic       stall_o, bubble_o, md_busy_o;

    rf_hazard_ctl #(.MD_CYCLES(MDC)) dut (
        .clk(clk), .rst_i(rst_i), .pause(pause), .flush_i(flush_i),
        .rs_n_i(rs_n_i), .rt_n_i(rt_n_i), .use_rs_i(use_rs_i), .use_rt_i(use_rt_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .is_load_i(is_load_i),
        .md_start_i(md_start_i), .md_read_i(md_read_i),
        .fw_cmp_rs(fw_cmp_rs), .fw_cmp_rt(fw_cmp_rt),
        .stall_o(stall_o), .bubble_o(bubble_o), .md_busy_o(md_busy_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: writes issued in the last three unpaused cycles, newest first,
    // and the unpaused-cycle index at which the last multiply/divide began.
    typedef struct packed {
        logic       v;
        logic [4:0] a;
        logic       ld;
    } wr_t;

    wr_t hist [3];
    int  ucyc;
    int  md_last;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        ucyc    = 0;
        md_last = -1000;
    endtask

    function automatic int ref_sel(input logic u, input logic [4:0] n);
        if (!u || n == 5'd0) return 0;
        for (int age = 0; age < 3; age++)
            if (hist[age].v && hist[age].a == n) return age + 1;
        return 0;
    endfunction

    function automatic bit ref_busy();
        int d;
        d = ucyc - md_last;
        return (d >= 0) && (d < MDC);
    endfunction

    function automatic bit ref_stall();
        bit ld, md;
        ld = (ref_sel(use_rs_i, rs_n_i) == 1 || ref_sel(use_rt_i, rt_n_i) == 1) && hist[0].ld;
        md = (md_read_i || md_start_i) && ref_busy() && !flush_i;
        return (ld || md) && !flush_i && !pause;
    endfunction

    task automatic model_step(input bit st);
        wr_t e;
        bit  iss;
        if (!pause) begin
            iss  = !flush_i && !st;
            e.v  = iss && wr_en_i && (wr_addr_i != 5'd0);
            e.a  = wr_addr_i;
            e.ld = is_load_i;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = e;
            ucyc++;
            if (md_start_i && iss) md_last = ucyc;
        end
    endtask

    // One clock: compare every output against the model mid-cycle, then advance both
    task automatic cyc();
        bit st;
        @(negedge clk);
        st = ref_stall();
        chk("fw_rs",  int'(fw_cmp_rs), ref_sel(use_rs_i, rs_n_i));
        chk("fw_rt",  int'(fw_cmp_rt), ref_sel(use_rt_i, rt_n_i));
        chk("stall",  int'(stall_o),   int'(st));
        chk("bubble", int'(bubble_o),  int'(st));
        chk("busy",   int'(md_busy_o), int'(ref_busy()));
        @(posedge clk);
        model_step(st);
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic we,
                          input logic [4:0] wa, input logic ld,
                          input logic ms, input logic mr);
        rs_n_i = rs;  rt_n_i = rt;  use_rs_i = urs;  use_rt_i = urt;
        wr_en_i = we; wr_addr_i = wa; is_load_i = ld;
        md_start_i = ms; md_read_i = mr;
    endtask

    task automatic nop();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int waited;
        rst_i = 1'b0; pause = 1'b0; flush_i = 1'b0;
        set_in(5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        model_reset();
        #3;
        chk("rst_fw_rs", int'(fw_cmp_rs), 0);
        chk("rst_stall", int'(stall_o),   0);
        chk("rst_busy",  int'(md_busy_o), 0);
        @(negedge clk); rst_i = 1'b1;
        @(posedge clk); #1;

        // ALU chain: producer r3, then a reader that ages through the slots
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0); cyc();
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("alu_ex",   int'(fw_cmp_rs), 1); cyc();
        #1 chk("alu_mem",  int'(fw_cmp_rs), 2); cyc();
        #1 chk("alu_wb",   int'(fw_cmp_rs), 3); cyc();
        #1 chk("alu_none", int'(fw_cmp_rs), 0); cyc();

        // Load-use: LW r5; ADD rt=r5
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); cyc();
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
        #1 chk("lu_stall",  int'(stall_o),   1);
        chk("lu_bubble",    int'(bubble_o),  1);
        cyc();
        #1 chk("lu_fw_mem", int'(fw_cmp_rt), 2);
        chk("lu_release",   int'(stall_o),   0);
        cyc();
        nop(); cyc(); cyc(); cyc();

        // Priority: r7 written three cycles in a row, youngest wins; $0 untracked
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); cyc(); cyc(); cyc();
        set_in(5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("prio_rs", int'(fw_cmp_rs), 1);
        chk("prio_rt",    int'(fw_cmp_rt), 1);
        cyc();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); cyc();
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("r0_fw",  int'(fw_cmp_rs), 0);
        chk("r0_stall",  int'(stall_o),   0);
        cyc();
        nop(); cyc(); cyc(); cyc();

        // Multiply: MFLO behind MULT waits exactly MDC cycles
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cyc();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        for (waited = 0; stall_o === 1'b1 && waited < 20; waited++) begin
            cyc(); #1;
        end
        chk("md_wait", waited, MDC);
        cyc();

        // Multiply with two paused cycles inside the busy window
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cyc();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        #1 chk("mdp_t1", int'(stall_o), 1); cyc();
        pause = 1'b1;
        #1 chk("mdp_pz1", int'(stall_o), 0);
        chk("mdp_busy",   int'(md_busy_o), 1);
        cyc();
        #1 chk("mdp_pz2", int'(stall_o), 0); cyc();
        pause = 1'b0;
        #1 chk("mdp_t4", int'(stall_o), 1); cyc();
        #1 chk("mdp_t5", int'(stall_o), 1); cyc();
        #1 chk("mdp_t6", int'(stall_o), 1); cyc();
        #1 chk("mdp_t7", int'(stall_o), 0); cyc();
        nop(); cyc();

        // Flush: LW r5 in EX, flushed dependent load/MULT in RF
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); cyc();
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        flush_i = 1'b1;
        #1 chk("fl_stall", int'(stall_o), 0); cyc();
        flush_i = 1'b0;
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("fl_fw",    int'(fw_cmp_rt), 2);
        chk("fl_nostall",  int'(stall_o),   0);
        chk("fl_nobusy",   int'(md_busy_o), 0);
        cyc();

        // Asynchronous reset in the middle of an MD stall
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0); cyc();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cyc();
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        #1 chk("mr_pre_fw", int'(fw_cmp_rs), 2);
        chk("mr_pre_stall", int'(stall_o),   1);
        cyc();
        #1 rst_i = 1'b0;
        #1 chk("mr_fw",   int'(fw_cmp_rs), 0);
        chk("mr_stall",   int'(stall_o),   0);
        chk("mr_bubble",  int'(bubble_o),  0);
        chk("mr_busy",    int'(md_busy_o), 0);
        model_reset();
        @(negedge clk); rst_i = 1'b1;
        @(posedge clk); #1;
        #1 chk("mr_after", int'(stall_o), 0);
        cyc();

        // Randomized traffic on a small register set to provoke frequent matches
        for (int i = 0; i < 600; i++) begin
            logic [4:0] ra, rb, wa;
            ra = 5'($urandom_range(0, 3));
            rb = 5'($urandom_range(0, 3));
            wa = 5'($urandom_range(0, 3));
            pause   = ($urandom_range(0, 9) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            set_in(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), wa, 1'($urandom_range(0, 2) == 0),
                   1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 3) == 0));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
